phase_rr_arbiter: RTL and testbench

//  Shares one 2-phase (transition-signalled) downstream channel between N_REQ upstream 2-phase channels.

---
 rtl/phase_rr_arbiter_pkg.sv | 16 +
 rtl/phase_rr_arbiter_if.sv | 35 +++
 rtl/phase_rr_arbiter_rr_pick.sv | 31 +++
 rtl/phase_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_phase_rr_arbiter.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_rr_arbiter_pkg.sv
// Shared definitions for the 2-phase round-robin arbiter: FSM state encoding and
// the grant-index width helper.
package hs_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } arbState_t;

    // A single requester still needs a 1-bit index so port widths never collapse to zero.
    function automatic int idWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_rr_arbiter_if.sv
// Bundle of upstream and downstream 2-phase handshake signals around the arbiter.
// The master side drives requests and the downstream ack; the slave side is the arbiter.
interface phase_rr_arbiter_if
    import hs_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = idWidth(N_REQ)
);

    logic [N_REQ-1:0] inR;
    logic [N_REQ-1:0] inA;
    logic             outR;
    logic             outA;
    logic [ID_W-1:0]  grant_id;
    logic             busy;

    modport master (
        output inR,
        output outA,
        input  inA,
        input  outR,
        input  grant_id,
        input  busy
    );

    modport slave (
        input  inR,
        input  outA,
        output inA,
        output outR,
        output grant_id,
        output busy
    );

endinterface

// File: rtl/phase_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first pending index found when
// searching last+1, last+2, ... modulo N_REQ.
module rr_pick
    import hs_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = idWidth(N_REQ)
) (
    input  logic [N_REQ-1:0] pending,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  sel,
    output logic             any
);

    logic [ID_W-1:0] idx;

    // The modulo keeps the candidate index in range even for non-power-of-two N_REQ.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(last) + 1 + k) % N_REQ);
            if (!any && pending[idx]) begin
                any = 1'b1;
                sel = idx;
            end
        end
    end

endmodule

// File: rtl/phase_rr_arbiter.sv
// Serialises N_REQ upstream 2-phase channels onto one downstream 2-phase channel, round-robin.
// Define ARB_SYNC_EN to pass inR/outA through 2-flop synchronisers (inputs may then be asynchronous).
module phase_rr_arbiter
    import hs_ctrl_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = idWidth(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    phase_rr_arbiter_if.slave bus
);

    logic [N_REQ-1:0] inRS;
    logic             outAS;

`ifdef ARB_SYNC_EN
    logic [N_REQ-1:0] inRMeta;
    logic [N_REQ-1:0] inRSync;
    logic             outAMeta;
    logic             outASync;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : gReqSync
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                inRMeta[gi] <= 1'b0;
                inRSync[gi] <= 1'b0;
            end else begin
                inRMeta[gi] <= bus.inR[gi];
                inRSync[gi] <= inRMeta[gi];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outAMeta <= 1'b0;
            outASync <= 1'b0;
        end else begin
            outAMeta <= bus.outA;
            outASync <= outAMeta;
        end
    end

    assign inRS  = inRSync;
    assign outAS = outASync;
`else
    assign inRS  = bus.inR;
    assign outAS = bus.outA;
`endif

    arbState_t        stateReg;
    logic [N_REQ-1:0] inAReg;
    logic             outRReg;
    logic [ID_W-1:0]  grantReg;
    logic [ID_W-1:0]  lastReg;
    logic             busyReg;

    logic [N_REQ-1:0] pending;
    logic [ID_W-1:0]  sel;
    logic             anyPending;
    logic             dsDone;

    // A requester is pending whenever its request phase differs from our ack phase.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : gPending
        assign pending[gi] = inRS[gi] ^ inAReg[gi];
    end

    assign dsDone = (outAS == outRReg);

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) uPick (
        .pending (pending),
        .last    (lastReg),
        .sel     (sel),
        .any     (anyPending)
    );

    // lastReg resets to N_REQ-1 so the very first search starts at requester 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg <= IDLE;
            inAReg   <= '0;
            outRReg  <= 1'b0;
            grantReg <= '0;
            lastReg  <= ID_W'(N_REQ - 1);
            busyReg  <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (anyPending) begin
                        grantReg <= sel;
                        outRReg  <= ~outRReg;
                        busyReg  <= 1'b1;
                        stateReg <= WAIT;
                    end
                end
                WAIT: begin
                    if (dsDone) begin
                        stateReg <= DONE;
                    end
                end
                DONE: begin
                    inAReg[grantReg] <= ~inAReg[grantReg];
                    lastReg          <= grantReg;
                    busyReg          <= 1'b0;
                    stateReg         <= IDLE;
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    assign bus.inA      = inAReg;
    assign bus.outR     = outRReg;
    assign bus.grant_id = grantReg;
    assign bus.busy     = busyReg;

endmodule

// File: tb/tb_phase_rr_arbiter.sv
// Scoreboard bench for phase_rr_arbiter: directed requester/ack sequences with expected
// grant ids and inA vectors queued up front and checked as outR/inA toggle.
module tb_phase_rr_arbiter;
    import hs_ctrl_pkg::*;

    localparam int N_REQ = 4;
    localparam int ID_W  = idWidth(N_REQ);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    phase_rr_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

    phase_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [ID_W-1:0]  expGrantQ[$];
    logic [N_REQ-1:0] expInAQ[$];

    logic ackEn    = 1'b1;
    logic ackNow   = 1'b0;
    logic flipOutA = 1'b0;
    int   ackCnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Downstream receiver: answers each outR toggle two cycles later unless stalled.
    always @(negedge clk) begin
        if (rst) begin
            bus.outA = 1'b0;
            ackCnt   = 0;
        end else if (flipOutA) begin
            bus.outA = ~bus.outA;
            flipOutA = 1'b0;
        end else if (bus.outA !== bus.outR) begin
            if (ackNow) begin
                bus.outA = bus.outR;
                ackNow   = 1'b0;
                ackCnt   = 0;
            end else if (ackEn) begin
                ackCnt++;
                if (ackCnt >= 2) begin
                    bus.outA = bus.outR;
                    ackCnt   = 0;
                end
            end
        end else begin
            ackCnt = 0;
        end
    end

    // Monitor: every outR toggle is a grant, every inA change is a completion.
    logic             prevOutR;
    logic [N_REQ-1:0] prevInA;
    always @(negedge clk) begin
        if (rst) begin
            prevOutR = 1'b0;
            prevInA  = '0;
        end else begin
            if (bus.outR !== prevOutR) begin
                prevOutR = bus.outR;
                checks++;
                if (expGrantQ.size() == 0) begin
                    errors++;
                    $display("FAIL grant: unexpected outR toggle grant_id=%0d expected none", bus.grant_id);
                end else begin
                    logic [ID_W-1:0] g;
                    g = expGrantQ.pop_front();
                    if (bus.grant_id !== g) begin
                        errors++;
                        $display("FAIL grant: grant_id=%0d expected %0d", bus.grant_id, g);
                    end else begin
                        $display("ok   grant: grant_id=%0d", bus.grant_id);
                    end
                end
            end
            if (bus.inA !== prevInA) begin
                prevInA = bus.inA;
                checks++;
                if (expInAQ.size() == 0) begin
                    errors++;
                    $display("FAIL ack: unexpected inA change to %b expected none", bus.inA);
                end else begin
                    logic [N_REQ-1:0] a;
                    a = expInAQ.pop_front();
                    if (bus.inA !== a) begin
                        errors++;
                        $display("FAIL ack: inA=%b expected %b", bus.inA, a);
                    end else begin
                        $display("ok   ack: inA=%b", bus.inA);
                    end
                end
            end
        end
    end

    task automatic drain(input string name);
        int n = 0;
        while ((expGrantQ.size() != 0 || expInAQ.size() != 0 || bus.busy !== 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s drain: %0d grants %0d acks still outstanding, expected 0",
                     name, expGrantQ.size(), expInAQ.size());
            expGrantQ.delete();
            expInAQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic waitBusy(input string name);
        int n = 0;
        while (bus.busy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL %s: busy=%b expected 1 within 50 cycles", name, bus.busy);
        end
    endtask

    task automatic waitInABit(input int b, input logic v);
        int n = 0;
        while (bus.inA[b] !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL wait inA[%0d]: value %b expected %b within 100 cycles", b, bus.inA[b], v);
        end
    endtask

    task automatic doReset();
        rst     = 1'b1;
        bus.inR = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.inR = '0;
        repeat (2) @(negedge clk);
        check("reset inA", 32'(bus.inA), 32'h0);
        check("reset outR", 32'(bus.outR), 32'h0);
        check("reset grant_id", 32'(bus.grant_id), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Single request on 0: outR must toggle on the very next edge.
        expGrantQ.push_back(2'd0);
        expInAQ.push_back(4'b0001);
        bus.inR = bus.inR ^ 4'b0001;
        @(negedge clk);
        check("single outR latency", 32'(bus.outR), 32'h1);
        check("single busy", 32'(bus.busy), 32'h1);
        drain("single");
        check("single inA", 32'(bus.inA), 32'h1);
        check("single busy idle", 32'(bus.busy), 32'h0);

        // All four at once from reset: served 0,1,2,3.
        doReset();
        expGrantQ.push_back(2'd0); expInAQ.push_back(4'b0001);
        expGrantQ.push_back(2'd1); expInAQ.push_back(4'b0011);
        expGrantQ.push_back(2'd2); expInAQ.push_back(4'b0111);
        expGrantQ.push_back(2'd3); expInAQ.push_back(4'b1111);
        bus.inR = 4'b1111;
        drain("all four");
        check("all four inA", 32'(bus.inA), 32'hF);

        // last=3, requests on 3 and 0: wrap gives 0 first.
        expGrantQ.push_back(2'd0); expInAQ.push_back(4'b1110);
        expGrantQ.push_back(2'd3); expInAQ.push_back(4'b0110);
        bus.inR = bus.inR ^ 4'b1001;
        drain("wrap");

        // 1 and 2 pending, each re-requests once after its ack: 1,2,1,2.
        expGrantQ.push_back(2'd1); expInAQ.push_back(4'b0100);
        expGrantQ.push_back(2'd2); expInAQ.push_back(4'b0000);
        expGrantQ.push_back(2'd1); expInAQ.push_back(4'b0010);
        expGrantQ.push_back(2'd2); expInAQ.push_back(4'b0110);
        bus.inR = bus.inR ^ 4'b0110;
        waitInABit(1, 1'b0);
        bus.inR = bus.inR ^ 4'b0010;
        waitInABit(2, 1'b0);
        bus.inR = bus.inR ^ 4'b0100;
        drain("alternate");

        // outA toggling while idle must change nothing.
        ackEn    = 1'b0;
        flipOutA = 1'b1;
        repeat (5) @(negedge clk);
        check("idle outA busy", 32'(bus.busy), 32'h0);
        check("idle outA outR", 32'(bus.outR), 32'h0);
        check("idle outA inA", 32'(bus.inA), 32'h6);
        flipOutA = 1'b1;
        repeat (2) @(negedge clk);

        // Stall 50 cycles in WAIT, then ack: inA toggles two edges later.
        expGrantQ.push_back(2'd0);
        expInAQ.push_back(4'b0111);
        bus.inR = bus.inR ^ 4'b0001;
        waitBusy("stall start");
        repeat (50) @(negedge clk);
        check("stall busy", 32'(bus.busy), 32'h1);
        check("stall inA", 32'(bus.inA), 32'h6);
        check("stall grant_id", 32'(bus.grant_id), 32'h0);
        @(posedge clk);
        ackNow = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ack +1 inA", 32'(bus.inA), 32'h6);
        @(negedge clk);
        check("ack +2 inA", 32'(bus.inA), 32'h7);
        ackEn = 1'b1;
        drain("stall");

        // Reset while waiting on requester 1, then a fresh request on 0.
        ackEn = 1'b0;
        expGrantQ.push_back(2'd1);
        bus.inR = bus.inR ^ 4'b0010;
        waitBusy("reset wait");
        @(negedge clk);
        rst     = 1'b1;
        bus.inR = '0;
        @(negedge clk);
        check("midreset inA", 32'(bus.inA), 32'h0);
        check("midreset outR", 32'(bus.outR), 32'h0);
        check("midreset busy", 32'(bus.busy), 32'h0);
        check("midreset grant_id", 32'(bus.grant_id), 32'h0);
        check("midreset grant popped", 32'(expGrantQ.size()), 32'h0);
        expGrantQ.delete();
        @(negedge clk);
        rst   = 1'b0;
        ackEn = 1'b1;
        @(negedge clk);
        expGrantQ.push_back(2'd0);
        expInAQ.push_back(4'b0001);
        bus.inR = bus.inR ^ 4'b0001;
        drain("after reset");
        check("after reset inA", 32'(bus.inA), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
